// File: rtl/mem_wb_stage.sv
// MEM stage data memory (big-endian byte array) plus the MEM/WB pipeline register.
// Optional MEM_ALIGN_TRAP_EN: misaligned half/word accesses trap instead of being force-aligned.
module mem_wb_stage #(
  parameter int unsigned ADDR_W = 9
) (
  input  logic        clk,
  input  logic        R,
  input  logic        hold,
  input  logic        load_mem,
  input  logic        rf_le_mem,
  input  logic        E_mem,
  input  logic [1:0]  size_mem,
  input  logic        rw_dm_mem,
  input  logic [31:0] alu_out_mem,
  input  logic [31:0] st_data_mem,
  input  logic [4:0]  rd_mem,
  output logic [31:0] wb_data,
  output logic [4:0]  rd_wb,
  output logic        rf_le_wb,
  output logic        align_trap
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] addr_raw, a0, a1, a2, a3;
  logic              is_half, is_word, trap_hit, mem_we;
  logic [31:0]       load_val, wb_data_d;
  logic              rf_le_d;
  logic              unused_addr_hi;

  // Upper address bits are ignored: the memory wraps modulo its depth.
  assign unused_addr_hi = ^alu_out_mem[31:ADDR_W];
  assign addr_raw       = alu_out_mem[ADDR_W-1:0];
  assign is_word        = size_mem[1];
  assign is_half        = (size_mem == 2'b01);

`ifdef MEM_ALIGN_TRAP_EN
  assign a0       = addr_raw;
  assign trap_hit = ((is_half & addr_raw[0]) | (is_word & (addr_raw[1:0] != 2'b00)))
                    & (load_mem | rw_dm_mem);
`else
  always_comb begin
    a0 = addr_raw;
    if (is_word) begin
      a0[1:0] = 2'b00;
    end else if (is_half) begin
      a0[0] = 1'b0;
    end
  end
  assign trap_hit = 1'b0;
`endif

  assign a1 = a0 + ADDR_W'(1);
  assign a2 = a0 + ADDR_W'(2);
  assign a3 = a0 + ADDR_W'(3);

  always_comb begin
    load_val = {mem[a0], mem[a1], mem[a2], mem[a3]};
    if (is_half) begin
      load_val = {{16{E_mem & mem[a0][7]}}, mem[a0], mem[a1]};
    end else if (!is_word) begin
      load_val = {{24{E_mem & mem[a0][7]}}, mem[a0]};
    end
  end

  always_comb begin
    wb_data_d = load_mem ? load_val : alu_out_mem;
    rf_le_d   = rf_le_mem;
    if (trap_hit) begin
      wb_data_d = 32'h0;
      rf_le_d   = 1'b0;
    end
  end

  assign mem_we = rw_dm_mem & ~hold & ~R & ~trap_hit;

  // Memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (is_word) begin
        mem[a0] <= st_data_mem[31:24];
        mem[a1] <= st_data_mem[23:16];
        mem[a2] <= st_data_mem[15:8];
        mem[a3] <= st_data_mem[7:0];
      end else if (is_half) begin
        mem[a0] <= st_data_mem[15:8];
        mem[a1] <= st_data_mem[7:0];
      end else begin
        mem[a0] <= st_data_mem[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      wb_data  <= 32'h0;
      rd_wb    <= 5'd0;
      rf_le_wb <= 1'b0;
    end else if (!hold) begin
      wb_data  <= wb_data_d;
      rd_wb    <= rd_mem;
      rf_le_wb <= rf_le_d;
    end
  end

`ifdef MEM_ALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (R) begin
      align_trap <= 1'b0;
    end else if (!hold) begin
      align_trap <= trap_hit;
    end
  end
`else
  assign align_trap = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed ops push expected MEM/WB values,
// a negedge monitor pops and compares them once the register has captured.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        R, hold, load_mem, rf_le_mem, E_mem, rw_dm_mem;
  logic [1:0]  size_mem;
  logic [31:0] alu_out_mem, st_data_mem;
  logic [4:0]  rd_mem;
  logic [31:0] wb_data;
  logic [4:0]  rd_wb;
  logic        rf_le_wb, align_trap;

  mem_wb_stage #(.ADDR_W(9)) dut (
    .clk         (clk),
    .R           (R),
    .hold        (hold),
    .load_mem    (load_mem),
    .rf_le_mem   (rf_le_mem),
    .E_mem       (E_mem),
    .size_mem    (size_mem),
    .rw_dm_mem   (rw_dm_mem),
    .alu_out_mem (alu_out_mem),
    .st_data_mem (st_data_mem),
    .rd_mem      (rd_mem),
    .wb_data     (wb_data),
    .rd_wb       (rd_wb),
    .rf_le_wb    (rf_le_wb),
    .align_trap  (align_trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] wb;
    logic [4:0]  rd;
    logic        rfle;
    logic        trap;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_wb;
  logic [4:0]  last_rd;
  logic        last_rfle, last_trap;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp += 4;
      if (wb_data !== e.wb) begin
        n_bad++;
        $display("FAIL %s wb_data: got %h want %h", e.name, wb_data, e.wb);
      end
      if (rd_wb !== e.rd) begin
        n_bad++;
        $display("FAIL %s rd_wb: got %0d want %0d", e.name, rd_wb, e.rd);
      end
      if (rf_le_wb !== e.rfle) begin
        n_bad++;
        $display("FAIL %s rf_le_wb: got %b want %b", e.name, rf_le_wb, e.rfle);
      end
      if (align_trap !== e.trap) begin
        n_bad++;
        $display("FAIL %s align_trap: got %b want %b", e.name, align_trap, e.trap);
      end
    end
  end

  task automatic drive(input logic r, input logic h, input logic ld, input logic rfle,
                       input logic e, input logic [1:0] sz, input logic rw,
                       input logic [31:0] alu, input logic [31:0] st, input logic [4:0] rd);
    R = r; hold = h; load_mem = ld; rf_le_mem = rfle; E_mem = e; size_mem = sz;
    rw_dm_mem = rw; alu_out_mem = alu; st_data_mem = st; rd_mem = rd;
  endtask

  task automatic expect_out(input string name, input logic [31:0] wb, input logic [4:0] rd,
                            input logic rfle, input logic trap);
    exp_t e;
    e.due = cyc + 1; e.wb = wb; e.rd = rd; e.rfle = rfle; e.trap = trap; e.name = name;
    sb.push_back(e);
    last_wb = wb; last_rd = rd; last_rfle = rfle; last_trap = trap;
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input string name, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] st);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, sz, 1'b1, addr, st, 5'd0);
    expect_out(name, addr, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_load(input string name, input logic [1:0] sz, input logic e,
                         input logic [31:0] addr, input logic [4:0] rd,
                         input logic [31:0] exp_wb);
    drive(1'b0, 1'b0, 1'b1, 1'b1, e, sz, 1'b0, addr, 32'h0, rd);
    expect_out(name, exp_wb, rd, 1'b1, 1'b0);
  endtask

  task automatic do_hold(input string name, input logic [31:0] addr, input logic [31:0] st);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, addr, st, 5'd9);
    expect_out(name, last_wb, last_rd, last_rfle, last_trap);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);
    @(posedge clk);
    #1;
    // Reset, including reset winning over hold
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd31);
    expect_out("reset1", 32'h0, 5'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h1111_1111, 32'h0, 5'd3);
    expect_out("reset2_hold", 32'h0, 5'd0, 1'b0, 1'b0);

    // Word store / loads, byte and half extension
    do_store("st_w10", 2'b10, 32'h010, 32'h8A2B_3C4D);
    do_load("ld_w10", 2'b10, 1'b0, 32'h010, 5'd1, 32'h8A2B_3C4D);
    do_load("ld_b10_s", 2'b00, 1'b1, 32'h010, 5'd2, 32'hFFFF_FF8A);
    do_load("ld_b10_z", 2'b00, 1'b0, 32'h010, 5'd3, 32'h0000_008A);
    do_load("ld_h12_z", 2'b01, 1'b0, 32'h012, 5'd4, 32'h0000_3C4D);
    do_load("ld_b13_s", 2'b00, 1'b1, 32'h013, 5'd5, 32'h0000_004D);

    // Halfword store over an initialised word
    do_store("st_w20", 2'b10, 32'h020, 32'h1122_3344);
    do_store("st_h22", 2'b01, 32'h022, 32'h0000_F00D);
    do_load("ld_h22_s", 2'b01, 1'b1, 32'h022, 5'd6, 32'hFFFF_F00D);
    do_load("ld_w20", 2'b10, 1'b0, 32'h020, 5'd7, 32'h1122_F00D);

    // ALU pass-through, then hold freezes outputs and blocks the store
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h1234_5678, 32'h0, 5'd7);
    expect_out("alu_op", 32'h1234_5678, 5'd7, 1'b1, 1'b0);
    do_hold("hold1", 32'h010, 32'hDEAD_BEEF);
    do_hold("hold2", 32'h010, 32'hDEAD_BEEF);
    do_load("ld_after_hold", 2'b10, 1'b0, 32'h010, 5'd8, 32'h8A2B_3C4D);

    // Address wrap modulo depth
    do_store("st_b210", 2'b00, 32'h0000_0210, 32'h0000_005A);
    do_load("ld_w10_wrap", 2'b10, 1'b0, 32'h010, 5'd9, 32'h5A2B_3C4D);

    // Simultaneous load+store returns old data; following load sees new data
    do_store("st_w30", 2'b10, 32'h030, 32'h0102_0304);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 32'h030, 32'hCAFE_BABE, 5'd10);
    expect_out("ldst_w30", 32'h0102_0304, 5'd10, 1'b1, 1'b0);
    do_load("ld_w30_new", 2'b10, 1'b0, 32'h030, 5'd11, 32'hCAFE_BABE);

    // Reset during a store suppresses the write
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 32'h030, 32'h7777_7777, 5'd12);
    expect_out("reset_st", 32'h0, 5'd0, 1'b0, 1'b0);
    do_load("ld_w30_kept", 2'b10, 1'b0, 32'h030, 5'd13, 32'hCAFE_BABE);

    // Misaligned accesses
`ifdef MEM_ALIGN_TRAP_EN
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h013, 32'h0, 5'd14);
    expect_out("ld_w13_trap", 32'h0, 5'd14, 1'b0, 1'b1);
    do_hold("trap_hold", 32'h040, 32'h0);
    do_load("ld_after_trap", 2'b10, 1'b0, 32'h010, 5'd15, 32'h5A2B_3C4D);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 32'h011, 32'hFFFF_FFFF, 5'd16);
    expect_out("st_w11_trap", 32'h0, 5'd16, 1'b0, 1'b1);
    do_load("ld_w10_unch", 2'b10, 1'b0, 32'h010, 5'd17, 32'h5A2B_3C4D);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 32'h023, 32'h0, 5'd18);
    expect_out("ld_h23_trap", 32'h0, 5'd18, 1'b0, 1'b1);
`else
    do_load("ld_w13_align", 2'b10, 1'b0, 32'h013, 5'd14, 32'h5A2B_3C4D);
    do_store("st_w11_align", 2'b10, 32'h011, 32'hFFFF_FFFF);
    do_load("ld_w10_new", 2'b10, 1'b0, 32'h010, 5'd17, 32'hFFFF_FFFF);
    do_load("ld_h23_align", 2'b01, 1'b1, 32'h023, 5'd18, 32'hFFFF_F00D);
`endif

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries never checked (want 0)", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
